// File: rtl/pipe_control_unit.sv
// Pipelined control unit: decodes the ID instruction into a control bundle and
// carries it through ID/EX, EX/MEM and MEM/WB, with load-use stall, branch flush and an illegal-opcode counter.
module pipe_control_unit #(
    parameter int ALUOP_W    = 3,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 8,
    parameter int HAZARD_EN  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  branch_taken,
    output logic                  id_jump,
    output logic                  id_stall,
    output logic [ALUOP_W-1:0]    ex_alu_op,
    output logic                  ex_alu_src,
    output logic                  ex_reg_dest,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  mem_beq,
    output logic                  wb_reg_write,
    output logic                  wb_mem_to_reg,
    output logic [CNT_W-1:0]      illegal_cnt
);

    typedef struct packed {
        logic       reg_write;
        logic       reg_dest;
        logic       alu_src;
        logic [2:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       beq;
    } idex_t;

    // Later stages keep only the fields still consumed downstream.
    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_read;
        logic mem_write;
        logic beq;
    } exmem_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } memwb_t;

    idex_t                 dec;
    idex_t                 idex;
    exmem_t                exmem;
    memwb_t                memwb;
    logic [REG_ADDR_W-1:0] ex_rt;
    logic                  illegal;
    logic                  jump_dec;
    logic                  hazard;
    logic                  count_en;

    always_comb begin
        dec      = '0;
        illegal  = 1'b0;
        jump_dec = 1'b0;
        case (opcode)
            6'b000000: begin
                dec.reg_write = 1'b1;
                dec.reg_dest  = 1'b1;
                case (funct)
                    6'b100000: dec.alu_op = 3'b010;
                    6'b100010: dec.alu_op = 3'b110;
                    6'b100100: dec.alu_op = 3'b000;
                    6'b100101: dec.alu_op = 3'b001;
                    6'b101010: dec.alu_op = 3'b111;
                    default:   illegal    = 1'b1;
                endcase
            end
            6'b100011: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.alu_op     = 3'b010;
            end
            6'b101011: begin
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                dec.alu_op    = 3'b010;
            end
            6'b000100: begin
                dec.beq    = 1'b1;
                dec.alu_op = 3'b110;
            end
            6'b001000: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = 3'b010;
            end
            6'b000010: jump_dec = 1'b1;
            default:   illegal  = 1'b1;
        endcase
        if (!id_valid || illegal) begin
            dec      = '0;
            jump_dec = 1'b0;
        end
    end

    always_comb begin
        hazard   = id_valid && idex.mem_read && (ex_rt != '0) &&
                   ((ex_rt == id_rs) || (ex_rt == id_rt));
        id_stall = (HAZARD_EN != 0) && hazard && !branch_taken;
        id_jump  = jump_dec && !branch_taken;
        count_en = id_valid && illegal && !id_stall && !branch_taken;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex        <= '0;
            exmem       <= '0;
            memwb       <= '0;
            ex_rt       <= '0;
            illegal_cnt <= '0;
        end else begin
            idex  <= (id_stall || branch_taken) ? '0 : dec;
            ex_rt <= id_rt;
            if (branch_taken) begin
                exmem <= '0;
            end else begin
                exmem.reg_write  <= idex.reg_write;
                exmem.mem_to_reg <= idex.mem_to_reg;
                exmem.mem_read   <= idex.mem_read;
                exmem.mem_write  <= idex.mem_write;
                exmem.beq        <= idex.beq;
            end
            memwb.reg_write  <= exmem.reg_write;
            memwb.mem_to_reg <= exmem.mem_to_reg;
            if (count_en && (illegal_cnt != '1)) begin
                illegal_cnt <= illegal_cnt + CNT_W'(1);
            end
        end
    end

    assign ex_alu_op     = ALUOP_W'(idex.alu_op);
    assign ex_alu_src    = idex.alu_src;
    assign ex_reg_dest   = idex.reg_dest;
    assign mem_read      = exmem.mem_read;
    assign mem_write     = exmem.mem_write;
    assign mem_beq       = exmem.beq;
    assign wb_reg_write  = memwb.reg_write;
    assign wb_mem_to_reg = memwb.mem_to_reg;

endmodule
